// File: rtl/pe_acc_drain_pkg.sv
// Shared parameters, FSM state type and the lane
// round/shift/ReLU/saturate step used by the drain and the PE writeback paths.
package pe_acc_drain_pkg;

    localparam int DATA_W     = 16;
    localparam int BATCH      = 4;
    localparam int RES_W      = 32;
    localparam int SHIFT_W    = 5;
    localparam int BUF_DEPTH  = 256;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    localparam int ADDR_W = $clog2(BUF_DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [RES_W:0] SAT_MAX = (RES_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [RES_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH
    } state_t;

    // Round half up, arithmetic shift, optional ReLU, saturate to DATA_W.
    function automatic logic [DATA_W-1:0] sat_round_shift(
        input logic signed [RES_W-1:0] x,
        input logic [SHIFT_W-1:0]      shift,
        input logic                    relu
    );
        logic signed [RES_W:0] t;
        t = {x[RES_W-1], x};
        if (shift != '0)
            t = t + ((RES_W+1)'(1) << (shift - SHIFT_W'(1)));
        t = t >>> shift;
        if (relu && t < 0)
            t = '0;
        if (t > SAT_MAX)
            t = SAT_MAX;
        else if (t < SAT_MIN)
            t = SAT_MIN;
        return t[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/pe_acc_drain_if.sv
// Output stream of processed batch vectors (valid/ready).
// The drain is the master; the output writer is the slave.
interface pe_acc_drain_if;
    import pe_acc_drain_pkg::*;

    logic [DATA_W*BATCH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/drain_fifo.sv
// Synchronous FIFO with a registered head entry driving the stream
// directly; a write into an empty (or draining) FIFO lands in the head.
module drain_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_occ
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rp;
    logic [PW-1:0] r_wp;
    logic [CW-1:0] r_bcnt;
    logic          r_hvld;
    logic [W-1:0]  r_head;

    logic w_free;
    logic w_from_body;
    logic w_to_head;
    logic w_to_body;

    assign w_free      = ~r_hvld | (r_hvld & i_ready);
    assign w_from_body = w_free & (r_bcnt != '0);
    assign w_to_head   = w_free & (r_bcnt == '0) & i_push;
    assign w_to_body   = i_push & ~w_to_head;

    assign o_valid = r_hvld;
    assign o_data  = r_head;
    assign o_occ   = r_bcnt + CW'(r_hvld);

    // Head register, pointers and body count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rp   <= '0;
            r_wp   <= '0;
            r_bcnt <= '0;
            r_hvld <= 1'b0;
            r_head <= '0;
        end else begin
            if (w_from_body) begin
                r_head <= r_mem[r_rp];
                r_rp   <= r_rp + 1'b1;
            end else if (w_to_head) begin
                r_head <= i_data;
            end
            if (w_free)
                r_hvld <= w_from_body | w_to_head;
            if (w_to_body)
                r_wp <= r_wp + 1'b1;
            r_bcnt <= r_bcnt + CW'(w_to_body) - CW'(w_from_body);
        end
    end

    // Body storage behind the head; no reset needed.
    always_ff @(posedge clk) begin
        if (w_to_body)
            r_mem[r_wp] <= i_data;
    end

endmodule

// File: rtl/pe_acc_drain.sv
// Drains one tile from the PE accumulation buffer into a processed
// output stream: FSM, address counter, credits and read-valid pipe.
module pe_acc_drain
    import pe_acc_drain_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [LEN_W-1:0]       len,
    input  logic [SHIFT_W-1:0]     shift,
    input  logic                   relu_en,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      abuf_rd_addr,
    input  logic [BATCH*RES_W-1:0] abuf_rd_data,
    pe_acc_drain_if.master         out_if
);

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_cnt;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_relu;
    logic               r_busy;
    logic               r_done;
    logic [RD_LAT-1:0]  r_vld;

    logic                    w_issue;
    logic                    w_load;
    logic                    w_zero;
    logic                    w_fin;
    logic                    w_credit;
    logic                    w_drained;
    logic                    w_hvld;
    logic                    w_pop;
    logic [OCC_W-1:0]        w_occ;
    logic [DATA_W*BATCH-1:0] w_proc;

    assign busy         = r_busy;
    assign done         = r_done;
    assign abuf_rd_addr = r_addr;

    assign out_if.out_valid = w_hvld;
    assign w_pop            = w_hvld & out_if.out_ready;

    assign w_credit  = (int'($countones(r_vld)) + int'(w_occ)) < FIFO_DEPTH;
    assign w_drained = (r_vld == '0) &&
                       ((w_occ == '0) || ((w_occ == OCC_W'(1)) && w_pop));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        w_zero      = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_zero = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_credit) begin
                    w_issue = 1'b1;
                    if (r_cnt == LEN_W'(1))
                        w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_drained) begin
                    w_fin       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latched parameters, address counter, status and read-valid pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_vld   <= '0;
        end else begin
            r_done <= w_zero | w_fin;
            r_vld  <= {r_vld[RD_LAT-2:0], w_issue};
            if (w_load) begin
                r_addr  <= base_addr;
                r_cnt   <= len;
                r_shift <= shift;
                r_relu  <= relu_en;
                r_busy  <= 1'b1;
            end else if (w_fin) begin
                r_busy <= 1'b0;
            end
            if (w_issue) begin
                r_addr <= r_addr + 1'b1;
                r_cnt  <= r_cnt - 1'b1;
            end
        end
    end

    // Per-lane round, shift, ReLU and saturate of the returning entry.
    always_comb begin
        w_proc = '0;
        for (int i = 0; i < BATCH; i++)
            w_proc[i*DATA_W +: DATA_W] =
                sat_round_shift(abuf_rd_data[i*RES_W +: RES_W], r_shift, r_relu);
    end

    drain_fifo #(
        .W     (DATA_W*BATCH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld[RD_LAT-1]),
        .i_data  (w_proc),
        .i_ready (out_if.out_ready),
        .o_valid (w_hvld),
        .o_data  (out_if.out_data),
        .o_occ   (w_occ)
    );

endmodule

// File: tb/tb_pe_acc_drain.sv
// Directed bench for pe_acc_drain: arithmetic vector table plus
// sequences for timing, wrap, backpressure, len=0 and mid-drain reset.
module tb_pe_acc_drain;
    import pe_acc_drain_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [ADDR_W-1:0]      base_addr;
    logic [LEN_W-1:0]       len;
    logic [SHIFT_W-1:0]     shift;
    logic                   relu_en;
    logic                   busy;
    logic                   done;
    logic [ADDR_W-1:0]      abuf_rd_addr;
    logic [BATCH*RES_W-1:0] abuf_rd_data;
    logic [BATCH*RES_W-1:0] p1;

    logic [BATCH*RES_W-1:0] mem [BUF_DEPTH];

    pe_acc_drain_if intf ();

    pe_acc_drain dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .len          (len),
        .shift        (shift),
        .relu_en      (relu_en),
        .busy         (busy),
        .done         (done),
        .abuf_rd_addr (abuf_rd_addr),
        .abuf_rd_data (abuf_rd_data),
        .out_if       (intf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle accumulation buffer read model.
    always @(posedge clk) begin
        p1           <= mem[abuf_rd_addr];
        abuf_rd_data <= p1;
    end

    typedef struct {
        logic [BATCH*RES_W-1:0] in;
        logic [SHIFT_W-1:0]     sh;
        logic                   relu;
        logic [63:0]            exp;
    } vec_t;

    vec_t tv [7];

    int n_chk = 0;
    int n_pass = 0;
    int t_start;
    int t_done;
    int t_fv;
    int t_last_acc;
    int unstable;
    int max_occ;
    logic busy_at_done;
    logic [63:0] got [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BATCH*RES_W-1:0] vec(input int v);
        return {4{v[31:0]}};
    endfunction

    function automatic logic [63:0] exp16(input int v);
        return {4{v[15:0]}};
    endfunction

    task automatic launch(input int b, input int l, input int s, input logic r);
        base_addr = ADDR_W'(b);
        len       = LEN_W'(l);
        shift     = SHIFT_W'(s);
        relu_en   = r;
        start     = 1'b1;
        t_start   = cyc;
        step();
        start = 1'b0;
    endtask

    // Runs until done (or budget), driving ready and logging beats.
    task automatic run_wait(input int budget, input int pat);
        logic       stall_prev;
        logic [63:0] prev_d;
        got.delete();
        t_done     = -1;
        t_fv       = -1;
        t_last_acc = -1;
        unstable   = 0;
        max_occ    = 0;
        stall_prev = 1'b0;
        prev_d     = '0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                t_done       = cyc;
                busy_at_done = busy;
                break;
            end
            intf.out_ready = (pat == 0) ? 1'b1 : (i % 3 == 0);
            if (intf.out_valid && t_fv < 0)
                t_fv = cyc;
            if (stall_prev && intf.out_data != prev_d)
                unstable++;
            if (intf.out_valid && intf.out_ready) begin
                got.push_back(intf.out_data);
                t_last_acc = cyc;
            end
            stall_prev = intf.out_valid & ~intf.out_ready;
            prev_d     = intf.out_data;
            if (int'(dut.w_occ) > max_occ)
                max_occ = int'(dut.w_occ);
            step();
        end
        chk("done_seen", 64'(t_done >= 0), 64'd1);
        intf.out_ready = 1'b1;
    endtask

    initial begin
        logic [ADDR_W-1:0] a_before;

        tv[0] = '{{32'h7FFFFFFF, 32'd7, 32'hFFFFFFFB, 32'h00010000},
                  5'd4, 1'b0, 64'h7FFF_0000_0000_1000};
        tv[1] = '{{32'h7FFFFFFF, 32'd7, 32'hFFFFFFFB, 32'h00010000},
                  5'd4, 1'b1, 64'h7FFF_0000_0000_1000};
        tv[2] = '{{32'hFFFFFF9C, 32'd100, 32'hFFFF63C0, 32'h00009C40},
                  5'd0, 1'b0, 64'hFF9C_0064_8000_7FFF};
        tv[3] = '{{32'hFFFFFF9C, 32'd100, 32'hFFFF63C0, 32'h00009C40},
                  5'd0, 1'b1, 64'h0000_0064_0000_7FFF};
        tv[4] = '{{32'd3, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF},
                  5'd1, 1'b0, 64'h0002_FFFF_0001_0000};
        tv[5] = '{{32'h80000000, 32'h7FFFFFFF, 32'h40000000, 32'hC0000000},
                  5'd31, 1'b0, 64'hFFFF_0001_0001_0000};
        tv[6] = '{{32'h80000000, 32'h7FFF8000, 32'hFFFF0000, 32'h12345678},
                  5'd16, 1'b1, 64'h0000_7FFF_0000_1234};

        for (int a = 0; a < BUF_DEPTH; a++)
            mem[a] = vec(a);

        rst            = 1'b0;
        start          = 1'b0;
        base_addr      = '0;
        len            = '0;
        shift          = '0;
        relu_en        = 1'b0;
        intf.out_ready = 1'b1;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(intf.out_valid), 64'd0);
        chk("rst_addr", 64'(abuf_rd_addr), 64'd0);
        chk("rst_data", intf.out_data, 64'd0);
        rst = 1'b1;
        step();

        // Basic drain, with an ignored start while busy.
        launch(0, 8, 0, 1'b0);
        chk("a_busy", 64'(busy), 64'd1);
        base_addr = 8'd50;
        len       = 9'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        run_wait(60, 0);
        chk("a_first_valid", 64'(t_fv), 64'(t_start + 4));
        chk("a_done_time", 64'(t_done), 64'(t_start + 12));
        chk("a_busy_at_done", 64'(busy_at_done), 64'd0);
        chk("a_beats", 64'(got.size()), 64'd8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("a_beat%0d", k), got[k], exp16(k));
        step();
        chk("a_done_pulse", 64'(done), 64'd0);
        repeat (6) step();
        chk("a_idle_busy", 64'(busy), 64'd0);
        chk("a_idle_valid", 64'(intf.out_valid), 64'd0);

        // Address wrap at the end of the buffer.
        launch(250, 10, 0, 1'b0);
        chk("b_addr0", 64'(abuf_rd_addr), 64'd250);
        run_wait(60, 0);
        chk("b_beats", 64'(got.size()), 64'd10);
        for (int k = 0; k < 10 && k < got.size(); k++)
            chk($sformatf("b_beat%0d", k), got[k], exp16((250 + k) % 256));

        // Arithmetic vectors, one single-entry drain each.
        for (int i = 0; i < 7; i++) begin
            mem[100] = tv[i].in;
            launch(100, 1, int'(tv[i].sh), tv[i].relu);
            run_wait(40, 0);
            chk($sformatf("arith%0d", i),
                (got.size() == 1) ? got[0] : 64'hDEAD_DEAD_DEAD_DEAD, tv[i].exp);
        end
        mem[100] = vec(100);

        // Backpressure with ready pattern 1,0,0,...
        launch(0, 6, 0, 1'b0);
        run_wait(200, 1);
        chk("d_beats", 64'(got.size()), 64'd6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            chk($sformatf("d_beat%0d", k), got[k], exp16(k));
        chk("d_stable", 64'(unstable), 64'd0);
        chk("d_occ_max", 64'(max_occ <= FIFO_DEPTH), 64'd1);
        chk("d_done_after_last", 64'(t_done), 64'(t_last_acc + 1));

        // Zero-length drain.
        a_before = abuf_rd_addr;
        launch(77, 0, 0, 1'b0);
        chk("e_done", 64'(done), 64'd1);
        chk("e_busy", 64'(busy), 64'd0);
        chk("e_addr", 64'(abuf_rd_addr), 64'(a_before));
        chk("e_valid", 64'(intf.out_valid), 64'd0);
        step();
        chk("e_done_pulse", 64'(done), 64'd0);
        chk("e_valid2", 64'(intf.out_valid), 64'd0);

        // Reset in the middle of a drain, then a clean restart.
        launch(0, 16, 0, 1'b0);
        repeat (4) step();
        chk("f_valid_before", 64'(intf.out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("f_busy", 64'(busy), 64'd0);
        chk("f_valid", 64'(intf.out_valid), 64'd0);
        chk("f_done", 64'(done), 64'd0);
        step();
        chk("f_done_hold", 64'(done), 64'd0);
        rst = 1'b1;
        step();
        chk("f_done_after", 64'(done), 64'd0);
        launch(40, 4, 0, 1'b0);
        run_wait(60, 0);
        chk("f_done_time", 64'(t_done), 64'(t_start + 8));
        chk("f_beats", 64'(got.size()), 64'd4);
        for (int k = 0; k < 4 && k < got.size(); k++)
            chk($sformatf("f_beat%0d", k), got[k], exp16(40 + k));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pe_acc_drain.md
# pe_acc_drain

Drains one tile of results from a PE accumulation buffer read port and emits them as a valid/ready stream of DATA_W-wide batch vectors. It sits directly downstream of the PE: it drives the PE's `abuf_rd_addr` and consumes `abuf_rd_data`. Each RES_W lane is rounded, shifted, optionally ReLU-clamped and saturated to DATA_W before it is handed to the output writer.

## Interface
- BUF_DEPTH, 256, accumulation buffer depth in entries; must match the PE.
- RD_LAT, 2, fixed accumulation buffer read latency in cycles, from address to data.
- FIFO_DEPTH, 4, output FIFO entries; must be ≥ RD_LAT+2.
- clk  in  1  the single clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that launches a drain; ignored while busy.
- base_addr  in  bw(BUF_DEPTH)  first entry to read; sampled on start.
- len  in  bw(BUF_DEPTH)+1  number of entries, 0..BUF_DEPTH; sampled on start.
- shift  in  5  arithmetic right-shift amount, 0..31; sampled on start.
- relu_en  in  1  clamp negative results to 0; sampled on start.
- busy  out  1  high from the cycle after start until the cycle done pulses.
- done  out  1  one-cycle pulse once the last beat is accepted.
- abuf_rd_addr  out  bw(BUF_DEPTH)  read address to the PE accumulation buffer.
- abuf_rd_data  in  BATCH*RES_W  read data, valid RD_LAT cycles after the address.
- out_data  out  DATA_W*BATCH  packed result vector; lane i is at bits [i*DATA_W +: DATA_W].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  the consumer accepts the beat when out_valid & out_ready.

## Operation
- FSM states are IDLE, ISSUE and FLUSH.
- IDLE:
  - On start with len>0, latch the parameters and go to ISSUE.
  - On start with len=0, go directly to a done pulse the next cycle. No reads are issued.
- ISSUE: issue one address per cycle while a credit is available.
  - Credit is available when in-flight + FIFO occupancy < FIFO_DEPTH.
  - Addresses are base_addr + k mod BUF_DEPTH, so the address wraps at BUF_DEPTH-1 → 0.
  - Go to FLUSH after issuing address len-1.
- FLUSH: wait until in-flight = 0, the FIFO is empty and the final beat has been accepted. Then pulse done and return to IDLE.
- In-flight tracking uses an RD_LAT-deep valid shift register aligned with abuf_rd_data.
- Per-lane arithmetic on the signed RES_W value x:
  - If shift>0, add 1<<(shift-1) in RES_W+1 bits (round half up). Then arithmetic-shift right by shift.
  - If relu_en and the result is < 0, the result becomes 0.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- The processed vector is written to the FIFO in the cycle the return is valid. The credit scheme guarantees the FIFO never overflows, so returns are never dropped.
- Beats leave the FIFO in address order.
- start during busy is ignored, and the latched parameters are unchanged.
- Reset mid-operation returns the FSM to IDLE, empties the FIFO and the in-flight register, and aborts the drain with no done pulse.
- Reset values:
  - busy=0, done=0, out_valid=0, abuf_rd_addr=0.
  - out_data=0. The FIFO head register is cleared.

## Timing
- start at cycle T → first abuf_rd_addr at T+1 → data return at T+1+RD_LAT → out_valid at T+2+RD_LAT.
- With out_ready held high, one beat is accepted per cycle with no bubbles.
- A drain of N entries completes with done at T+2+RD_LAT+N, i.e. the cycle after the last acceptance.
- When out_ready is low, issue stalls once credits run out, and resumes the cycle after a FIFO pop frees a credit.
- out_data and out_valid are registered and do not change while out_valid & ~out_ready.
- done and busy are registered. busy falls in the same cycle done pulses.

## Structure
- Add SHIFT_W=5 to GLOBAL_PARAM next to DATA_W, BATCH, RES_W and bw.
- Declare the lane round/saturate step as a package function, sat_round_shift(x, shift, relu). The PE writeback paths reuse it.
- The output FIFO is one sub-module, `drain_fifo`: synchronous, registered head, with occupancy output.
- The top level holds the FSM, the address counter, the credit logic and the RD_LAT valid shift register.

## Test plan
All scenarios use DATA_W=16, RES_W=32, BATCH=4, RD_LAT=2.
- base=0, len=8, shift=0, out_ready=1, buffer[k]=k per lane → 8 beats valued 0..7, first out_valid at T+4, done at T+12.
- base=250, len=10 (BUF_DEPTH=256) → addresses 250..255, 0..3 in order; 10 beats; no dropped or duplicated beat.
- Lane values 0x0001_0000, -5, 7, 0x7FFF_FFFF with shift=4, relu_en=0 → 4096, 0, 0 (7+8=15 >> 4 = 0), 32767 (saturated). The same input with relu_en=1 makes lane 1 read 0.
- len=6, out_ready toggling 1,0,0,1,… → exactly 6 beats, held stable while stalled; occupancy never exceeds 4; done only after the 6th acceptance.
- len=0 → done pulses at T+1, no abuf_rd_addr change, out_valid stays 0. A second start while busy is ignored.
- Assert reset at T+5 of a len=16 drain → busy, out_valid and done go 0 immediately with no done pulse. A new start then drains cleanly from its own base.
